// File: rtl/tag_ct_accumulator_pkg.sv
// Shared constants for the tag/count accumulator and the BD tag merge stage.
// Both blocks import this package so their widths and word code stay in step.
package tag_ct_accumulator_pkg;

   localparam int NTAG_DEF     = 11;
   localparam int NCT_DEF      = 9;
   localparam int NTIMEOUT_DEF = 16;

   // Word code the merge stage uses to recognise tag/count words.
   localparam int TAG_CT_CODE  = 30;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   function automatic int ct_max(input int nct);
      return (1 << nct) - 1;
   endfunction

   localparam int CT_MAX = ct_max(NCT_DEF);

endpackage

// File: rtl/tag_ct_out_slot.sv
// One-entry valid/ready output register with a load port.
// The owner only asserts load when slot_avail is high.
module tag_ct_out_slot #(
   parameter int Ntag = 11,
   parameter int Nct  = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [Ntag-1:0] load_tag,
   input  logic [Nct-1:0]  load_ct,
   input  logic            out_a,
   output logic            out_v,
   output logic [Ntag-1:0] out_tag,
   output logic [Nct-1:0]  out_ct,
   output logic            slot_avail
);

   logic            out_v_q, out_v_d;
   logic [Ntag-1:0] out_tag_q, out_tag_d;
   logic [Nct-1:0]  out_ct_q, out_ct_d;

   // A load in the same cycle as a transfer replaces the word rather than clearing it.
   always_comb begin
      out_v_d   = out_v_q;
      out_tag_d = out_tag_q;
      out_ct_d  = out_ct_q;
      if (load) begin
         out_v_d   = 1'b1;
         out_tag_d = load_tag;
         out_ct_d  = load_ct;
      end else if (out_v_q && out_a) begin
         out_v_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_v_q   <= 1'b0;
         out_tag_q <= '0;
         out_ct_q  <= '0;
      end else begin
         out_v_q   <= out_v_d;
         out_tag_q <= out_tag_d;
         out_ct_q  <= out_ct_d;
      end
   end

   assign out_v      = out_v_q;
   assign out_tag    = out_tag_q;
   assign out_ct     = out_ct_q;
   assign slot_avail = !out_v_q || out_a;

endmodule

// File: rtl/tag_ct_accumulator.sv
// Run-length accumulator: collapses runs of identical routing tags into (tag, ct)
// words for the merge stage, spilling on tag change, saturation, idle timeout or flush.
module tag_ct_accumulator
   import tag_ct_accumulator_pkg::*;
#(
   parameter int Ntag     = NTAG_DEF,
   parameter int Nct      = NCT_DEF,
   parameter int Ntimeout = NTIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tag_in_v,
   input  logic [Ntag-1:0]     tag_in_d,
   output logic                tag_in_a,
   input  logic [Ntimeout-1:0] conf_timeout,
   input  logic                flush,
   output logic                tag_ct_out_v,
   output logic [Ntag-1:0]     tag_ct_out_tag,
   output logic [Nct-1:0]      tag_ct_out_ct,
   input  logic                tag_ct_out_a
);

   localparam logic [Nct-1:0] CT_TOP = Nct'(ct_max(Nct));

   logic [0:0]          state_q, state_d;
   logic [Ntag-1:0]     acc_tag_q, acc_tag_d;
   logic [Nct-1:0]      acc_ct_q, acc_ct_d;
   logic [Ntimeout-1:0] idle_cnt_q, idle_cnt_d;

   logic                is_accum;
   logic                same_tag;
   logic                mismatch;
   logic                saturate;
   logic                timeout;
   logic                spill;
   logic                accept;
   logic                slot_avail;
   logic [Ntimeout:0]   idle_next;

   // The timeout compares the count it is about to reach, so a tag accepted at
   // edge k spills on edge k+conf_timeout.
   always_comb begin
      is_accum  = (state_q == ST_ACCUM);
      same_tag  = (tag_in_d == acc_tag_q);
      mismatch  = tag_in_v && !same_tag;
      saturate  = tag_in_v && same_tag && (acc_ct_q == CT_TOP);
      idle_next = {1'b0, idle_cnt_q} + (Ntimeout+1)'(1);
      timeout   = (conf_timeout != '0) && (idle_next >= {1'b0, conf_timeout});
      spill     = is_accum && slot_avail && (mismatch || saturate || timeout || flush);
      tag_in_a  = reset && (!is_accum || (same_tag && (acc_ct_q != CT_TOP)) || spill);
      accept    = tag_in_v && tag_in_a;
   end

   always_comb begin
      state_d    = state_q;
      acc_tag_d  = acc_tag_q;
      acc_ct_d   = acc_ct_q;
      idle_cnt_d = idle_cnt_q;
      if (accept) begin
         if (!is_accum || spill) begin
            state_d   = ST_ACCUM;
            acc_tag_d = tag_in_d;
            acc_ct_d  = Nct'(1);
         end else begin
            acc_ct_d  = acc_ct_q + Nct'(1);
         end
      end else if (spill) begin
         state_d = ST_EMPTY;
      end

      // Idle count saturates at conf_timeout so lowering it triggers a spill next cycle.
      if (accept || (state_d == ST_EMPTY)) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q >= conf_timeout) begin
         idle_cnt_d = conf_timeout;
      end else begin
         idle_cnt_d = idle_cnt_q + Ntimeout'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_EMPTY;
         acc_tag_q  <= '0;
         acc_ct_q   <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_tag_q  <= acc_tag_d;
         acc_ct_q   <= acc_ct_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   tag_ct_out_slot #(
      .Ntag (Ntag),
      .Nct  (Nct)
   ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (spill),
      .load_tag   (acc_tag_q),
      .load_ct    (acc_ct_q),
      .out_a      (tag_ct_out_a),
      .out_v      (tag_ct_out_v),
      .out_tag    (tag_ct_out_tag),
      .out_ct     (tag_ct_out_ct),
      .slot_avail (slot_avail)
   );

endmodule

// File: tb/tb_tag_ct_accumulator.sv
// Directed bench for tag_ct_accumulator: reset, run/flush, saturation, timeout,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_tag_ct_accumulator;

   logic        clk;
   logic        reset;
   logic        tag_in_v;
   logic [10:0] tag_in_d;
   logic        tag_in_a;
   logic [15:0] conf_timeout;
   logic        flush;
   logic        out_v;
   logic [10:0] out_tag;
   logic [8:0]  out_ct;
   logic        out_a;

   int checks = 0;
   int errors = 0;
   int quiet;
   int drops;
   int nwords;
   logic [10:0] w_tag [2];
   logic [8:0]  w_ct  [2];

   tag_ct_accumulator dut (
      .clk            (clk),
      .reset          (reset),
      .tag_in_v       (tag_in_v),
      .tag_in_d       (tag_in_d),
      .tag_in_a       (tag_in_a),
      .conf_timeout   (conf_timeout),
      .flush          (flush),
      .tag_ct_out_v   (out_v),
      .tag_ct_out_tag (out_tag),
      .tag_ct_out_ct  (out_ct),
      .tag_ct_out_a   (out_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and land 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
      end
   endtask

   task automatic check_word(input string name, input logic [10:0] tag, input logic [8:0] ct);
      check_output({name, "_v"}, 32'(out_v), 32'd1);
      check_output({name, "_tag"}, 32'(out_tag), 32'(tag));
      check_output({name, "_ct"}, 32'(out_ct), 32'(ct));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset        = 1'b0;
      tag_in_v     = 1'b0;
      tag_in_d     = '0;
      conf_timeout = '0;
      flush        = 1'b0;
      out_a        = 1'b1;

      // Reset and idle
      #2;
      check_output("rst_in_a", 32'(tag_in_a), 32'd0);
      check_output("rst_out_v", 32'(out_v), 32'd0);
      check_output("rst_out_tag", 32'(out_tag), 32'd0);
      check_output("rst_out_ct", 32'(out_ct), 32'd0);
      repeat (3) step();
      reset = 1'b1;
      #1;
      check_output("post_rst_in_a", 32'(tag_in_a), 32'd1);
      check_output("post_rst_out_v", 32'(out_v), 32'd0);
      quiet = 0;
      repeat (100) begin
         step();
         if (out_v) quiet++;
      end
      check_output("idle_no_out", 32'(quiet), 32'd0);

      // Run of 0x1A x5 then 0x2B, then flush
      for (int i = 0; i < 5; i++) begin
         tag_in_v = 1'b1;
         tag_in_d = 11'h1A;
         step();
      end
      tag_in_d = 11'h2B;
      #1;
      check_output("mismatch_in_a", 32'(tag_in_a), 32'd1);
      step();
      tag_in_v = 1'b0;
      check_word("run_1a", 11'h1A, 9'd5);
      step();
      check_output("run_cleared", 32'(out_v), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_word("flush_2b", 11'h2B, 9'd1);
      step();
      check_output("flush_cleared", 32'(out_v), 32'd0);

      // Saturation: 1023 back-to-back tag 3 with timeout 4
      conf_timeout = 16'd4;
      drops  = 0;
      nwords = 0;
      for (int i = 0; i < 1023; i++) begin
         tag_in_v = 1'b1;
         tag_in_d = 11'd3;
         #1;
         if (!tag_in_a) drops++;
         step();
         if (out_v) begin
            if (nwords < 2) begin
               w_tag[nwords] = out_tag;
               w_ct[nwords]  = out_ct;
            end
            nwords++;
         end
      end
      tag_in_v = 1'b0;
      check_output("sat_no_stall", 32'(drops), 32'd0);
      check_output("sat_nwords", 32'(nwords), 32'd2);
      check_output("sat_w0_tag", 32'(w_tag[0]), 32'd3);
      check_output("sat_w0_ct", 32'(w_ct[0]), 32'd511);
      check_output("sat_w1_tag", 32'(w_tag[1]), 32'd3);
      check_output("sat_w1_ct", 32'(w_ct[1]), 32'd511);
      repeat (3) step();
      check_output("sat_tail_early", 32'(out_v), 32'd0);
      step();
      check_word("sat_tail", 11'd3, 9'd1);
      step();
      check_output("sat_tail_cleared", 32'(out_v), 32'd0);

      // Timeout of 8 after a single tag
      conf_timeout = 16'd8;
      tag_in_v = 1'b1;
      tag_in_d = 11'd7;
      step();
      tag_in_v = 1'b0;
      repeat (7) step();
      check_output("to_early", 32'(out_v), 32'd0);
      step();
      check_word("to_word", 11'd7, 9'd1);
      step();

      // Timeout disabled: hold until flush
      conf_timeout = 16'd0;
      tag_in_v = 1'b1;
      tag_in_d = 11'd7;
      step();
      tag_in_v = 1'b0;
      quiet = 0;
      repeat (20) begin
         step();
         if (out_v) quiet++;
      end
      check_output("to_off_quiet", 32'(quiet), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_word("to_off_flush", 11'd7, 9'd1);
      step();

      // Backpressure: 1,2,3 with out_a low
      out_a    = 1'b0;
      tag_in_v = 1'b1;
      tag_in_d = 11'd1;
      step();
      tag_in_d = 11'd2;
      #1;
      check_output("bp_in_a_2", 32'(tag_in_a), 32'd1);
      step();
      check_word("bp_hold1", 11'd1, 9'd1);
      tag_in_d = 11'd3;
      #1;
      check_output("bp_stall_a", 32'(tag_in_a), 32'd0);
      step();
      check_word("bp_hold1b", 11'd1, 9'd1);
      check_output("bp_stall_a2", 32'(tag_in_a), 32'd0);
      out_a = 1'b1;
      #1;
      check_output("bp_release_a", 32'(tag_in_a), 32'd1);
      step();
      tag_in_v = 1'b0;
      check_word("bp_word2", 11'd2, 9'd1);
      step();
      check_output("bp_drained", 32'(out_v), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_word("bp_word3", 11'd3, 9'd1);
      step();
      check_output("bp_end", 32'(out_v), 32'd0);

      // Asynchronous reset mid-run with acc_ct=4 and a held word
      out_a    = 1'b0;
      tag_in_v = 1'b1;
      tag_in_d = 11'd1;
      step();
      tag_in_d = 11'd4;
      repeat (4) step();
      tag_in_v = 1'b0;
      check_word("ar_before", 11'd1, 9'd1);
      #2;
      reset = 1'b0;
      #1;
      check_output("ar_out_v", 32'(out_v), 32'd0);
      check_output("ar_out_ct", 32'(out_ct), 32'd0);
      check_output("ar_in_a", 32'(tag_in_a), 32'd0);
      step();
      reset = 1'b1;
      out_a = 1'b1;
      #1;
      check_output("ar_release_a", 32'(tag_in_a), 32'd1);
      tag_in_v = 1'b1;
      tag_in_d = 11'd9;
      step();
      tag_in_v = 1'b0;
      quiet = 0;
      repeat (5) begin
         step();
         if (out_v) quiet++;
      end
      check_output("ar_quiet", 32'(quiet), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_word("ar_word9", 11'd9, 9'd1);
      step();
      check_output("ar_end", 32'(out_v), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
